data_mem_ctrl: RTL
==================

# data_mem_ctrl

Parametrised, word-addressed data memory for the core's MEM stage, with a request/response handshake, byte-enabled stores and out-of-range detection. Partial stores run as an internal read-modify-write. An optional memory-mapped display register latches store data for the board display. The block sits between the ALU/shift address path and the write-back mux, with one clock domain.

## Interface
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 10: word-index width; depth is 2**ADDR_W words.
- DISP_ADDR, 32'h0000_0400: effective word address of the display register.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  base word address.
- req_offset  in  32  offset word count, added to req_addr.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte enables for stores; ignored for loads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range, qualified by rsp_valid.
- display  out  DATA_W  display register value.

## Operation
- Effective address: ea = req_addr + req_offset, computed mod 2**32 with carry discarded.
- Address decode, evaluated in this priority order:
  - ea == DISP_ADDR (macro on): display access.
  - ea[31:ADDR_W] != 0: error.
  - Otherwise: memory word ea[ADDR_W-1:0].
- Accept condition: req_valid && req_ready. Request fields are captured at the accept edge.
- FSM states: IDLE, RD, RMW, RESP. Reset state is IDLE.
- Transitions out of IDLE on accept:
  - Store with req_be all ones: memory written at the accept edge, go to RESP.
  - Store with partial req_be, nonzero: go to RMW.
  - Store with req_be == 0: no write, go to RESP.
  - Load: go to RD.
  - Error: no memory access, go to RESP with rsp_err = 1.
  - Display store: display updated at the accept edge by byte-lane merge, go to RESP.
  - Display load: go to RD; returns display.
- RD: synchronous RAM read; go to RESP with the data registered into rsp_rdata.
- RMW: read old word, merge enabled bytes of the captured wdata, write the merged word at the end of RMW, go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Memory contents are not initialised and not affected by rst.

## Timing
- Accept edge is T. Full store, display store, zero-be store and error: rsp_valid high in cycle T+1.
- Load and partial store: rsp_valid high in cycle T+2.
- req_ready is low from T until the return to IDLE. The earliest next accept is T+2 (1-cycle paths) or T+3.
- A load issued after a store sees the stored data, including RMW results.
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, display = 0, FSM = IDLE.
- rst asserted mid-operation: FSM returns to IDLE at once and any pending response is dropped.
  - A partial store still in RMW is abandoned with the memory word unchanged.
  - A full store committed at an edge before rst remains written.
- rsp_rdata and rsp_err hold their values after rsp_valid drops until the next response.

## Configuration
- DATAMEM_DISPLAY_EN defined: DISP_ADDR decode is active and display behaves as described above.
- DATAMEM_DISPLAY_EN undefined:
  - display is tied to 0.
  - DISP_ADDR receives no special decode and follows the normal range/memory rules. With default parameters that makes it an error.

## Test plan
- Full store, then load: after reset, store 32'hDEAD_BEEF at addr 5 + offset 3, be 4'hF, then load addr 8 offset 0. Required: store rsp_valid at T+1; load rsp_valid at T+2 with rsp_rdata 32'hDEAD_BEEF and rsp_err 0.
- Partial store: with word 8 holding 32'hDEAD_BEEF, store 32'h1122_3344 with be 4'b0101, then load word 8. Required: store rsp at T+2; rsp_rdata 32'hDE22_BE44.
- Out of range: load addr 32'h3FF + offset 1 (ea 32'h400) with the macro off. Required: rsp_err 1, rsp_rdata 0. Same request with the macro on: rsp_err 0, display value returned. Also check wrap: addr 32'hFFFF_FFFF + offset 2 (ea 1) accesses word 1.
- Display: with the macro on, store 32'hCAFE_0001 be 4'hF, then 32'h0000_00AB be 4'b0001, both to DISP_ADDR. Required: display = 32'hCAFE_0001 at T+1 of the first store, then 32'hCAFE_00AB; memory word 0 unchanged.
- Reset mid-RMW: with word 2 holding 32'h0, assert rst during RMW of a be 4'b0011 store of 32'hFFFF_FFFF. Required:
  - immediately: outputs at reset values, no rsp_valid;
  - afterwards: a load of word 2 returns 32'h0.
- Handshake: hold req_valid high continuously with back-to-back loads. Required: req_ready pulses one cycle every 3 cycles; exactly one rsp_valid per accepted request.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory for the MEM stage with a valid/ready request handshake and byte-enabled stores.
// Define DATAMEM_DISPLAY_EN to map a display register at DISP_ADDR.
module data_mem_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] DISP_ADDR = 32'h0000_0400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_offset,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   display
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RMW,
    RESP
  } state_t;

  state_t              state_q;
  logic                reqReady_q;
  logic                rspValid_q;
  logic [DATA_W-1:0]   rspRdata_q;
  logic                rspErr_q;
  logic [DATA_W-1:0]   display_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [BeW-1:0]      be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                dispSel_q;
  logic [DATA_W-1:0]   rdWord_q;

  logic [DATA_W-1:0]   mem [Depth];

  logic [31:0]         ea;
  logic [ADDR_W-1:0]   eaIdx;
  logic                isDisp;
  logic                isErr;
  logic                accept;
  logic                beFull;
  logic                beZero;
  logic                fullWe;
  logic                rmwWe;
  logic                memWe;
  logic                memRe;
  logic [ADDR_W-1:0]   wIdx;
  logic [DATA_W-1:0]   wData;
  logic [DATA_W-1:0]   rmwMerged_d;
  logic [DATA_W-1:0]   dispMerged_d;

`ifdef DATAMEM_DISPLAY_EN
  localparam logic DispEnable = 1'b1;
  assign display = display_q;
`else
  localparam logic DispEnable = 1'b0;
  assign display = '0;
`endif

  // The display match outranks the range check so DISP_ADDR may sit above the memory.
  assign ea     = req_addr + req_offset;
  assign eaIdx  = ea[ADDR_W-1:0];
  assign isDisp = DispEnable && (ea == DISP_ADDR);
  assign isErr  = !isDisp && (ea[31:ADDR_W] != '0);
  assign accept = req_valid && reqReady_q;
  assign beFull = &req_be;
  assign beZero = ~|req_be;

  assign fullWe = accept && req_we && !isDisp && !isErr && beFull;
  assign rmwWe  = (state_q == RMW);
  assign memWe  = !rst && (fullWe || rmwWe);
  assign memRe  = !rst && accept && !isDisp && !isErr;
  assign wIdx   = rmwWe ? idx_q : eaIdx;
  assign wData  = rmwWe ? rmwMerged_d : req_wdata;

  always_comb begin
    rmwMerged_d  = rdWord_q;
    dispMerged_d = display_q;
    for (int i = 0; i < BeW; i++) begin
      if (be_q[i]) rmwMerged_d[8*i +: 8] = wdata_q[8*i +: 8];
      if (req_be[i]) dispMerged_d[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // RAM array and its registered read port carry no reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[wIdx] <= wData;
    if (memRe) rdWord_q <= mem[eaIdx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      display_q  <= '0;
      idx_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      dispSel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rspValid_q <= 1'b0;
          if (accept) begin
            reqReady_q <= 1'b0;
            idx_q      <= eaIdx;
            be_q       <= req_be;
            wdata_q    <= req_wdata;
            dispSel_q  <= isDisp;
            if (isErr) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b1;
              rspRdata_q <= '0;
            end else if (!req_we) begin
              state_q <= RD;
            end else if (isDisp) begin
              display_q  <= dispMerged_d;
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b0;
              rspRdata_q <= '0;
            end else if (beFull || beZero) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b0;
              rspRdata_q <= '0;
            end else begin
              state_q <= RMW;
            end
          end
        end
        RD: begin
          state_q    <= RESP;
          rspValid_q <= 1'b1;
          rspErr_q   <= 1'b0;
          rspRdata_q <= dispSel_q ? display_q : rdWord_q;
        end
        RMW: begin
          state_q    <= RESP;
          rspValid_q <= 1'b1;
          rspErr_q   <= 1'b0;
          rspRdata_q <= '0;
        end
        RESP: begin
          state_q    <= IDLE;
          rspValid_q <= 1'b0;
          reqReady_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          rspValid_q <= 1'b0;
          reqReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

endmodule
